// File: rtl/ex_mem_reg.sv
// rtl/ex_mem_reg.sv - EX/MEM pipeline register with stall/flush control and accumulate hold state
// Optional feature macro: EX_MEM_MADD_EN (multiply-accumulate partial product and phase registers)
module ex_mem_reg #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                stall_ex,
   input  logic                stall_mem,
   input  logic                flush,
   input  logic [ADDR_W-1:0]   ex_wd,
   input  logic                ex_wreg,
   input  logic [DATA_W-1:0]   ex_wdata,
   input  logic                ex_whilo,
   input  logic [DATA_W-1:0]   ex_hi,
   input  logic [DATA_W-1:0]   ex_lo,
   input  logic [2*DATA_W-1:0] hilo_temp_i,
   input  logic [1:0]          cnt_i,
   output logic [ADDR_W-1:0]   mem_wd,
   output logic                mem_wreg,
   output logic [DATA_W-1:0]   mem_wdata,
   output logic                mem_whilo,
   output logic [DATA_W-1:0]   mem_hi,
   output logic [DATA_W-1:0]   mem_lo,
   output logic [2*DATA_W-1:0] hilo_temp_o,
   output logic [1:0]          cnt_o
);

   // Per-cycle action after resolving the control priority. Reset and
   // flush share an action: both produce an empty stage with no
   // accumulate state carried forward.
   typedef enum logic [1:0] {
      ACT_CLEAR   = 2'b00,
      ACT_HOLD    = 2'b01,
      ACT_BUBBLE  = 2'b10,
      ACT_ADVANCE = 2'b11
   } act_t;

   act_t act;

   // Resolve rst > flush > both-stalled hold > bubble > advance > illegal-combo hold
   always_comb begin
      act = ACT_HOLD;
      if (rst || flush) begin
         act = ACT_CLEAR;
      end else if (stall_ex && stall_mem) begin
         act = ACT_HOLD;
      end else if (stall_ex) begin
         act = ACT_BUBBLE;
      end else if (!stall_mem) begin
         act = ACT_ADVANCE;
      end else begin
         // MEM stalled while EX runs cannot legally happen upstream;
         // holding avoids both dropping and duplicating an instruction.
         act = ACT_HOLD;
      end
   end

   // MEM-side write-back registers: load on advance, zero on bubble/clear, keep on hold
   always_ff @(posedge clk) begin
      case (act)
         ACT_CLEAR, ACT_BUBBLE: begin
            mem_wd    <= '0;
            mem_wreg  <= 1'b0;
            mem_wdata <= '0;
            mem_whilo <= 1'b0;
            mem_hi    <= '0;
            mem_lo    <= '0;
         end
         ACT_ADVANCE: begin
            mem_wd    <= ex_wd;
            mem_wreg  <= ex_wreg;
            mem_wdata <= ex_wdata;
            mem_whilo <= ex_whilo;
            mem_hi    <= ex_hi;
            mem_lo    <= ex_lo;
         end
         default: begin
         end
      endcase
   end

`ifdef EX_MEM_MADD_EN
   // Accumulate phase: only IDLE and the first-phase code are ever stored;
   // any other incoming phase code collapses back to IDLE.
   typedef enum logic [1:0] {
      PH_IDLE = 2'b00,
      PH_ONE  = 2'b01
   } phase_t;

   phase_t              phase;
   logic [2*DATA_W-1:0] hilo_temp_q;

   // Accumulate FSM: capture partial product while EX is stalled, drop it when the instruction leaves or is discarded
   always_ff @(posedge clk) begin
      case (act)
         ACT_CLEAR, ACT_ADVANCE: begin
            phase       <= PH_IDLE;
            hilo_temp_q <= '0;
         end
         ACT_BUBBLE: begin
            hilo_temp_q <= hilo_temp_i;
            phase       <= (cnt_i == 2'b01) ? PH_ONE : PH_IDLE;
         end
         default: begin
         end
      endcase
   end

   assign hilo_temp_o = hilo_temp_q;
   assign cnt_o       = phase;
`else
   // Accumulate support absent: the returned state is constant and the
   // EX-side accumulate inputs are deliberately left without a sink.
   logic unused_madd_inputs;

   assign unused_madd_inputs = ^{hilo_temp_i, cnt_i};
   assign hilo_temp_o        = '0;
   assign cnt_o              = 2'b00;
`endif

endmodule

// File: tb/tb_ex_mem_reg.sv
// tb/tb_ex_mem_reg.sv - randomized bench for ex_mem_reg against a behavioural model
module tb_ex_mem_reg;

   localparam int DATA_W = 32;
   localparam int ADDR_W = 5;
`ifdef EX_MEM_MADD_EN
   localparam bit MADD = 1'b1;
`else
   localparam bit MADD = 1'b0;
`endif

   logic                clk = 1'b0;
   logic                rst, stall_ex, stall_mem, flush;
   logic [ADDR_W-1:0]   ex_wd;
   logic                ex_wreg;
   logic [DATA_W-1:0]   ex_wdata;
   logic                ex_whilo;
   logic [DATA_W-1:0]   ex_hi, ex_lo;
   logic [2*DATA_W-1:0] hilo_temp_i;
   logic [1:0]          cnt_i;
   logic [ADDR_W-1:0]   mem_wd;
   logic                mem_wreg;
   logic [DATA_W-1:0]   mem_wdata;
   logic                mem_whilo;
   logic [DATA_W-1:0]   mem_hi, mem_lo;
   logic [2*DATA_W-1:0] hilo_temp_o;
   logic [1:0]          cnt_o;

   ex_mem_reg #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
      .clk(clk), .rst(rst), .stall_ex(stall_ex), .stall_mem(stall_mem), .flush(flush),
      .ex_wd(ex_wd), .ex_wreg(ex_wreg), .ex_wdata(ex_wdata),
      .ex_whilo(ex_whilo), .ex_hi(ex_hi), .ex_lo(ex_lo),
      .hilo_temp_i(hilo_temp_i), .cnt_i(cnt_i),
      .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata),
      .mem_whilo(mem_whilo), .mem_hi(mem_hi), .mem_lo(mem_lo),
      .hilo_temp_o(hilo_temp_o), .cnt_o(cnt_o)
   );

   always #5 clk = ~clk;

   int vectors   = 0;
   int miscompares = 0;

   // Expected stage contents: what instruction (if any) sits in MEM and
   // what accumulate state has been parked for EX.
   logic [ADDR_W-1:0]   e_wd;
   logic                e_wreg;
   logic [DATA_W-1:0]   e_wdata;
   logic                e_whilo;
   logic [DATA_W-1:0]   e_hi, e_lo;
   logic [2*DATA_W-1:0] e_temp;
   logic [1:0]          e_cnt;

   task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      vectors++;
      if (obs !== exp) begin
         miscompares++;
         $display("FAIL %s t=%0t got=%0h want=%0h", tag, $time, obs, exp);
      end
   endtask

   task automatic empty_stage();
      e_wd = '0; e_wreg = 1'b0; e_wdata = '0; e_whilo = 1'b0; e_hi = '0; e_lo = '0;
   endtask

   // Reference: what the pipeline should contain after one clock edge
   task automatic model_edge();
      bit ex_moves  = !stall_ex;
      bit mem_moves = !stall_mem;
      if (rst || flush) begin
         empty_stage();
         e_temp = '0; e_cnt = 2'd0;
      end else if (ex_moves && mem_moves) begin
         e_wd = ex_wd; e_wreg = ex_wreg; e_wdata = ex_wdata;
         e_whilo = ex_whilo; e_hi = ex_hi; e_lo = ex_lo;
         e_temp = '0; e_cnt = 2'd0;
      end else if (!ex_moves && mem_moves) begin
         empty_stage();
         if (MADD) begin
            e_temp = hilo_temp_i;
            e_cnt  = (cnt_i == 2'd1) ? 2'd1 : 2'd0;
         end
      end
      // every other combination leaves the stage exactly as it was
   endtask

   task automatic compare_all(input string ph);
      check_eq({ph, ".mem_wd"},      128'(mem_wd),      128'(e_wd));
      check_eq({ph, ".mem_wreg"},    128'(mem_wreg),    128'(e_wreg));
      check_eq({ph, ".mem_wdata"},   128'(mem_wdata),   128'(e_wdata));
      check_eq({ph, ".mem_whilo"},   128'(mem_whilo),   128'(e_whilo));
      check_eq({ph, ".mem_hi"},      128'(mem_hi),      128'(e_hi));
      check_eq({ph, ".mem_lo"},      128'(mem_lo),      128'(e_lo));
      check_eq({ph, ".hilo_temp_o"}, 128'(hilo_temp_o), 128'(e_temp));
      check_eq({ph, ".cnt_o"},       128'(cnt_o),       128'(e_cnt));
   endtask

   task automatic step(input string ph);
      @(posedge clk);
      model_edge();
      #1;
      compare_all(ph);
   endtask

   task automatic set_ctl(input logic r, input logic f, input logic se, input logic sm);
      rst = r; flush = f; stall_ex = se; stall_mem = sm;
   endtask

   task automatic rand_ex();
      ex_wd = ADDR_W'($urandom); ex_wreg = 1'($urandom); ex_wdata = $urandom;
      ex_whilo = 1'($urandom); ex_hi = $urandom; ex_lo = $urandom;
      hilo_temp_i = {$urandom, $urandom}; cnt_i = 2'($urandom);
   endtask

   initial begin
      // reset with every input driven high
      set_ctl(1, 1, 1, 1);
      ex_wd = '1; ex_wreg = 1; ex_wdata = '1; ex_whilo = 1; ex_hi = '1; ex_lo = '1;
      hilo_temp_i = '1; cnt_i = 2'b11;
      step("reset");
      check_eq("reset.wdata_zero", 128'(mem_wdata), 128'd0);

      // plain advance
      set_ctl(0, 0, 0, 0);
      ex_wd = 5'd9; ex_wreg = 1; ex_wdata = 32'h1234_5678;
      ex_whilo = 0; ex_hi = 32'h0; ex_lo = 32'h0; cnt_i = 2'b00; hilo_temp_i = '0;
      step("advance");
      check_eq("advance.wdata_lit", 128'(mem_wdata), 128'h1234_5678);
      check_eq("advance.wd_lit", 128'(mem_wd), 128'd9);

      // bubble capturing first accumulate phase, then advance
      set_ctl(0, 0, 1, 0);
      cnt_i = 2'b01; hilo_temp_i = 64'h0000_0001_FFFF_FFFE; ex_whilo = 1;
      step("bubble_acc");
      set_ctl(0, 0, 1, 0);
      step("bubble_acc2");
      set_ctl(0, 0, 0, 0);
      ex_wd = 5'd3; ex_wreg = 1; ex_wdata = 32'hCAFE_0001; ex_whilo = 1;
      ex_hi = 32'hAAAA_5555; ex_lo = 32'h5555_AAAA;
      step("acc_done");

      // both stalled for three cycles with changing EX inputs
      for (int i = 0; i < 3; i++) begin
         set_ctl(0, 0, 1, 1);
         rand_ex();
         step("freeze");
      end

      // park a phase, then flush while both stages are stalled
      set_ctl(0, 0, 1, 0);
      cnt_i = 2'b01; hilo_temp_i = 64'h0123_4567_89AB_CDEF;
      step("park");
      set_ctl(0, 1, 1, 1);
      rand_ex();
      step("flush_stalled");

      // illegal combination holds, unsupported phase codes collapse to idle
      set_ctl(0, 0, 0, 0); rand_ex(); step("load");
      set_ctl(0, 0, 0, 1); rand_ex(); step("illegal_hold");
      set_ctl(0, 0, 1, 0); rand_ex(); cnt_i = 2'b10; step("code10");
      set_ctl(0, 0, 1, 0); rand_ex(); cnt_i = 2'b11; step("code11");

      // rst rising between edges must not disturb outputs
      set_ctl(0, 0, 0, 0); rand_ex(); step("pre_rst");
      #1 rst = 1;
      #2 compare_all("rst_midcycle");
      step("rst_edge");

      // randomized traffic, including resets during accumulation
      for (int i = 0; i < 3000; i++) begin
         set_ctl(($urandom_range(0, 31) == 0), ($urandom_range(0, 15) == 0),
                 1'($urandom), ($urandom_range(0, 3) == 0));
         rand_ex();
         if ($urandom_range(0, 1) == 0) cnt_i = 2'b01;
         step("random");
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
